dl_rr_arb8: RTL and testbench
=============================

Name: dl_rr_arb8

Overview:
- 8-requester round-robin arbiter that shares one downstream valid/ready channel.
- Selects the winning requester's data through an internal 8:1 mux driven by the registered grant index.
- A grant locks for a whole multi-beat packet and releases on the accepted beat with last set.
- Sits in front of shared resources: memory port, writeback bus, debug/CSR channel.

Parameters:
- NUM_BITS, 32, width of each requester's data payload.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  8  per-requester valid; bit i belongs to requester i.
- req_last  input  8  per-requester end-of-packet flag; qualified by req_valid[i].
- req_data  input  8*NUM_BITS  packed payloads; requester i occupies [i*NUM_BITS +: NUM_BITS].
- req_ready  output  8  per-requester ready; at most one bit set.
- out_valid  output  1  downstream valid.
- out_last  output  1  downstream end-of-packet.
- out_data  output  NUM_BITS  downstream payload.
- out_ready  input  1  downstream ready.
- grant_sel  output  3  current owner index; mux select.
- busy  output  1  1 while in GRANT state.

Behaviour:
- Reset: state=IDLE, ptr=0, grant_sel=0, busy=0. While rst is high or in IDLE: out_valid=0, out_last=0, req_ready=0. out_data = requester grant_sel data (don't-care while out_valid=0).
- States: IDLE, GRANT.
- IDLE:
  - If req_valid==0, stay in IDLE.
  - Otherwise pick the winner: first i with req_valid[i]=1, scanning ptr, ptr+1, ... ptr+7, modulo 8.
  - Next cycle: grant_sel=winner, ptr=winner+1 (mod 8, 7 wraps to 0), state=GRANT.
  - Arbitration latency: 1 cycle from req_valid assertion to first possible out_valid.
- GRANT, combinational pass-through, g=grant_sel:
  - out_valid = req_valid[g]
  - out_last = req_last[g]
  - out_data = requester g data
  - req_ready[g] = out_ready; every other req_ready bit = 0.
- Beat transfer: out_valid && out_ready in the same cycle.
- Transfer with out_last=1: next state IDLE. This forces one idle bubble between packets; no back-to-back re-arbitration.
- Transfer with out_last=0: stay in GRANT, grant_sel unchanged.
- Owner deasserting req_valid mid-packet: stay in GRANT, out_valid=0. The grant is never revoked before last.
- Non-owners are blocked for the whole packet regardless of their req_valid.
- Grant stability: grant_sel changes only on the IDLE to GRANT transition.
- ptr changes only when a grant is issued.
- Single-beat packet: req_last=1 on its first beat.
- Fairness: a continuously requesting source waits at most 7 packets.
- Reset mid-packet: next cycle IDLE, ptr=0, all outputs at reset values. The partial packet is dropped; no recovery is attempted.
- Combinational paths: out_ready to req_ready, and req_* to out_*. There is no combinational path from out_ready to out_valid.

Test Plan:
- Reset then req_valid=8'h01, last=1, data0=0xA5A5A5A5, out_ready=1 -> grant_sel=0 one cycle later; out_valid=1, out_data=0xA5A5A5A5, req_ready=8'h01 for one cycle; IDLE next; ptr=1.
- req_valid=8'hFF held, all single-beat, out_ready=1 -> grant order 0,1,2,...,7,0; each grant lasts exactly 1 beat with 1 idle cycle between grants.
- Requester 3 sends a 4-beat packet with req_valid[5] also high, out_ready toggling 1,0,1,1,1 -> grant_sel stays 3 through all 4 transfers; req_ready[5]=0 throughout; requester 5 is granted after last is accepted.
- ptr=7 (after granting 6), req_valid=8'h03 -> grant goes to 0 (wrap); ptr=1.
- Owner drops req_valid for 2 cycles mid-packet while out_ready=1 -> out_valid=0, state stays GRANT, grant_sel unchanged; packet resumes afterwards.
- rst pulsed during beat 2 of a 3-beat packet -> next cycle out_valid=0, req_ready=0, busy=0, ptr=0; a new request re-arbitrates from index 0.

Source files
------------

// File: rtl/dl_rr_arb8.sv
// Eight-requester round-robin arbiter that locks one valid/ready channel for a whole packet.
// The grant index is registered and selects the winner's payload through an 8:1 mux.
module dl_rr_arb8 #(
  parameter int NUM_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            req_valid,
  input  logic [7:0]            req_last,
  input  logic [8*NUM_BITS-1:0] req_data,
  output logic [7:0]            req_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [NUM_BITS-1:0]   out_data,
  input  logic                  out_ready,
  output logic [2:0]            grant_sel,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt, sel_nxt;
  logic [2:0] winner;
  logic       found;

  // Rotating priority scan: the first requester at or after ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && req_valid[ptr + 3'(k)]) begin
        winner = ptr + 3'(k);
        found  = 1'b1;
      end
    end
  end

  // Pass-through is gated by rst so a mid-packet reset stops the transfer immediately.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    req_ready = '0;
    if (state == GRANT && !rst) begin
      out_valid            = req_valid[grant_sel];
      out_last             = req_last[grant_sel];
      req_ready[grant_sel] = out_ready;
    end
  end

  assign out_data = req_data[grant_sel*NUM_BITS +: NUM_BITS];
  assign busy     = (state == GRANT);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = grant_sel;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          ptr_nxt   = winner + 3'd1;
        end
      end
      GRANT: begin
        if (out_valid && out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_sel <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_dl_rr_arb8.sv
// Self-checking bench for dl_rr_arb8: directed vector table, hand sequences for packet
// locking and reset, then random traffic against a packet-level reference model.
module tb_dl_rr_arb8;

  localparam int NB = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      req_valid, req_last, req_ready;
  logic [8*NB-1:0] req_data;
  logic            out_valid, out_last, out_ready, busy;
  logic [NB-1:0]   out_data;
  logic [2:0]      grant_sel;

  always #5 clk = ~clk;

  dl_rr_arb8 #(.NUM_BITS(NB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .grant_sel(grant_sel), .busy(busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: who owns the channel, and where the next search starts.
  bit       m_busy;
  int       m_owner;
  int       m_ptr;
  logic [31:0] d[8];

  // Sampled DUT outputs from the latest step, for the table and hand sequences.
  logic [2:0] s_sel;
  logic       s_busy, s_ov, s_ol;
  logic [7:0] s_rdy;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0;
  endtask

  // One clock cycle: drive, compare against model before the edge, advance model at the edge.
  task automatic step(input logic r, input logic [7:0] v, input logic [7:0] l, input logic ordy);
    bit       e_ov, e_ol;
    logic [7:0] e_rdy;
    rst = r; req_valid = v; req_last = l; out_ready = ordy;
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom;
      req_data[i*NB +: NB] = d[i];
    end
    @(negedge clk);
    e_ov = 0; e_ol = 0; e_rdy = '0;
    if (m_busy && !r) begin
      e_ov = v[m_owner];
      e_ol = l[m_owner];
      e_rdy = ordy ? 8'(1 << m_owner) : 8'h00;
    end
    s_sel = grant_sel; s_busy = busy; s_ov = out_valid; s_ol = out_last; s_rdy = req_ready;
    check("m_grant_sel", 32'(grant_sel), 32'(m_owner));
    check("m_busy", 32'(busy), 32'(m_busy));
    check("m_out_valid", 32'(out_valid), 32'(e_ov));
    check("m_out_last", 32'(out_last), 32'(e_ol));
    check("m_req_ready", 32'(req_ready), 32'(e_rdy));
    if (e_ov) check("m_out_data", out_data, d[m_owner]);
    @(posedge clk);
    if (r) model_reset();
    else if (!m_busy) begin
      if (v != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (v[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            break;
          end
        end
        m_ptr  = (m_owner + 1) % 8;
        m_busy = 1;
      end
    end else if (v[m_owner] && ordy && l[m_owner]) begin
      m_busy = 0;
    end
    #1;
  endtask

  typedef struct {
    logic       r;
    logic [7:0] v, l;
    logic       ordy;
    logic [2:0] e_sel;
    logic       e_busy, e_ov, e_ol;
    logic [7:0] e_rdy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int beats;
    logic [7:0] l;
    logic [7:0] rv;

    // reset, single beat from 0, wrap from ptr=7, owner stalls mid-packet
    tbl[0]  = '{1'b1, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h01, 8'h01, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'h01};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'h40, 8'h40, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h40, 8'h40, 1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 8'h40};
    tbl[6]  = '{1'b0, 8'h03, 8'h03, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 8'h03, 8'h03, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'h01};
    tbl[8]  = '{1'b0, 8'h03, 8'h03, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'h02};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'h02};
    tbl[11] = '{1'b0, 8'h02, 8'h02, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 8'h02};
    tbl[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00};

    rst = 1; req_valid = 0; req_last = 0; out_ready = 0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].ordy);
      check($sformatf("t%0d_sel", i), 32'(s_sel), 32'(tbl[i].e_sel));
      check($sformatf("t%0d_busy", i), 32'(s_busy), 32'(tbl[i].e_busy));
      check($sformatf("t%0d_ov", i), 32'(s_ov), 32'(tbl[i].e_ov));
      check($sformatf("t%0d_ol", i), 32'(s_ol), 32'(tbl[i].e_ol));
      check($sformatf("t%0d_rdy", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
    end

    // 4-beat packet from 3 while 5 waits; out_ready pattern 1,0,1,1,1
    step(1'b0, 8'h28, 8'h00, 1'b1);
    beats = 0;
    for (int c = 0; c < 5; c++) begin
      logic ordy;
      ordy = (c != 1);
      l = (beats == 3) ? 8'h28 : 8'h00;
      step(1'b0, 8'h28, l, ordy);
      check("lock_sel3", 32'(s_sel), 32'd3);
      check("lock_rdy5", 32'(s_rdy[5]), 32'd0);
      check("lock_rdy3", 32'(s_rdy[3]), 32'(ordy));
      if (ordy) beats++;
    end
    step(1'b0, 8'h20, 8'h20, 1'b1);
    check("bubble_idle", 32'(s_busy), 32'd0);
    step(1'b0, 8'h20, 8'h20, 1'b1);
    check("next_sel5", 32'(s_sel), 32'd5);
    check("next_busy", 32'(s_busy), 32'd1);

    // reset during beat 2 of a 3-beat packet from requester 4
    step(1'b0, 8'h10, 8'h00, 1'b1);
    step(1'b0, 8'h10, 8'h00, 1'b1);
    check("pre_rst_sel4", 32'(s_sel), 32'd4);
    step(1'b1, 8'h10, 8'h00, 1'b1);
    check("rst_ov_gated", 32'(s_ov), 32'd0);
    step(1'b0, 8'hFF, 8'h00, 1'b1);
    check("post_rst_busy", 32'(s_busy), 32'd0);
    check("post_rst_ov", 32'(s_ov), 32'd0);
    check("post_rst_rdy", 32'(s_rdy), 32'd0);
    step(1'b0, 8'hFF, 8'hFF, 1'b1);
    check("rearb_from0", 32'(s_sel), 32'd0);

    // all requesting single beats: 0..7,0 with one idle bubble between grants
    step(1'b1, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 18; k++) begin
      step(1'b0, 8'hFF, 8'hFF, 1'b1);
      check("rr_busy", 32'(s_busy), 32'(k % 2));
      if (k % 2 == 1) check("rr_order", 32'(s_sel), 32'(((k - 1) / 2) % 8));
    end

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rv = 8'($urandom) & 8'($urandom);
      l  = 8'($urandom) & 8'($urandom);
      step(($urandom_range(0, 199) == 0), rv, l, 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
